// File: rtl/tff_counter.sv
// ----------------------------------------------------------------------------
// tff_counter: parametrised up/down counter built from WIDTH toggle stages.
// Each bit updates as q[i] <= q[i] ^ t[i]. The toggle vector t carries the
// binary carry/borrow chain, the terminal-state jump for short moduli, the
// saturate hold, and the parallel-load value.
// Latency: q and wrap update one clock edge after the inputs; tc and nq are
// combinational from q (tc also from up).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (q=RESET_VAL, wrap=0)
//   en   - count enable
//   up   - direction, 1 = increment, 0 = decrement
//   load - synchronous parallel load (beats en), value clamped to MODULUS-1
//   d    - load value
//   q    - current count, always in 0..MODULUS-1
//   nq   - bitwise complement of q
//   tc   - terminal count for the current direction
//   wrap - one-cycle pulse after an edge that wrapped the count
// ----------------------------------------------------------------------------
module tff_counter #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter bit SATURATE  = 1'b0,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL    = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO_VAL   = '0;
   // With a power-of-two modulus the natural carry/borrow already wraps.
   localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;

   logic             w_at_max;
   logic             w_at_zero;
   logic             w_term;
   logic [WIDTH-1:0] w_t_inc;
   logic [WIDTH-1:0] w_t_dec;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_t;
   logic             w_wrap_nxt;

   assign w_at_max  = (r_q == MAX_VAL);
   assign w_at_zero = (r_q == ZERO_VAL);
   assign w_term    = up ? w_at_max : w_at_zero;

   // Binary toggle chains: a bit toggles on increment when every lower bit
   // is 1, and on decrement when every lower bit is 0.
   always_comb begin
      w_t_inc    = '0;
      w_t_dec    = '0;
      w_t_inc[0] = 1'b1;
      w_t_dec[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_t_inc[i] = w_t_inc[i-1] & r_q[i-1];
         w_t_dec[i] = w_t_dec[i-1] & ~r_q[i-1];
      end
   end

   // Load clamp. A full-range counter can represent every d, so no compare.
   generate
      if (FULL_RANGE) begin : g_load_full
         assign w_load_val = d;
      end else begin : g_load_clamp
         assign w_load_val = (d > MAX_VAL) ? MAX_VAL : d;
      end
   endgenerate

   // Toggle vector selection, priority load > en > hold.
   always_comb begin
      w_t        = '0;
      w_wrap_nxt = 1'b0;
      if (load) begin
         w_t = r_q ^ w_load_val;
      end else if (en) begin
         if (w_term && SATURATE) begin
            w_t = '0;
         end else if (w_term && !FULL_RANGE) begin
            // Short modulus: force the jump. Going up q==MAX -> 0 toggles
            // every set bit; going down q==0 -> MAX toggles MAX's set bits.
            w_t = up ? r_q : (r_q ^ MAX_VAL);
         end else begin
            w_t = up ? w_t_inc : w_t_dec;
         end
         w_wrap_nxt = w_term && !SATURATE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q    <= RST_VAL;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= r_q ^ w_t;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign q    = r_q;
   assign nq   = ~r_q;
   assign tc   = w_term;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_tff_counter.sv
// ----------------------------------------------------------------------------
// tb_tff_counter: drives four counter configurations from shared inputs and
// compares every output against an integer reference model after each
// input change and after each rising edge.
// ----------------------------------------------------------------------------
module tb_tff_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;

   logic [3:0] q0, nq0, q1, nq1, q2, nq2;
   logic [1:0] q3, nq3;
   logic       tc0, tc1, tc2, tc3;
   logic       w0, w1, w2, w3;

   // Configurations: M10 wrap RV3, M10 saturate, M16 full range, M2 in 2 bits.
   int M   [4] = '{10, 10, 16, 2};
   int SAT [4] = '{0, 1, 0, 0};
   int RV  [4] = '{3, 0, 0, 1};
   int MSK [4] = '{15, 15, 15, 3};

   int mq [4];
   int mw [4];

   int n_checks = 0;
   int n_pass   = 0;

   tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(3)) u_c0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .q(q0), .nq(nq0), .tc(tc0), .wrap(w0));
   tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(0)) u_c1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .q(q1), .nq(nq1), .tc(tc1), .wrap(w1));
   tff_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VAL(0)) u_c2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
      .q(q2), .nq(nq2), .tc(tc2), .wrap(w2));
   tff_counter #(.WIDTH(2), .MODULUS(2), .SATURATE(1'b0), .RESET_VAL(1)) u_c3 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d[1:0]),
      .q(q3), .nq(nq3), .tc(tc3), .wrap(w3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   function automatic int get_q(input int k);
      case (k)
         0: return int'(q0);
         1: return int'(q1);
         2: return int'(q2);
         default: return int'(q3);
      endcase
   endfunction

   function automatic int get_nq(input int k);
      case (k)
         0: return int'(nq0);
         1: return int'(nq1);
         2: return int'(nq2);
         default: return int'(nq3);
      endcase
   endfunction

   function automatic int get_tc(input int k);
      case (k)
         0: return int'(tc0);
         1: return int'(tc1);
         2: return int'(tc2);
         default: return int'(tc3);
      endcase
   endfunction

   function automatic int get_w(input int k);
      case (k)
         0: return int'(w0);
         1: return int'(w1);
         2: return int'(w2);
         default: return int'(w3);
      endcase
   endfunction

   // Reference model: one rising edge, from the counting rules in plain integers.
   task automatic model_edge();
      int dk;
      for (int k = 0; k < 4; k++) begin
         dk = int'(d) & MSK[k];
         if (rst) begin
            mq[k] = RV[k];
            mw[k] = 0;
         end else if (load) begin
            mq[k] = (dk < M[k]) ? dk : M[k] - 1;
            mw[k] = 0;
         end else if (en) begin
            if (up) begin
               if (mq[k] < M[k] - 1) begin mq[k] = mq[k] + 1; mw[k] = 0; end
               else if (SAT[k] != 0)  begin mw[k] = 0; end
               else                   begin mq[k] = 0; mw[k] = 1; end
            end else begin
               if (mq[k] > 0)         begin mq[k] = mq[k] - 1; mw[k] = 0; end
               else if (SAT[k] != 0)  begin mw[k] = 0; end
               else                   begin mq[k] = M[k] - 1; mw[k] = 1; end
            end
         end else begin
            mw[k] = 0;
         end
      end
   endtask

   task automatic check_all(input string ph);
      int exp_tc;
      for (int k = 0; k < 4; k++) begin
         exp_tc = up ? int'(mq[k] == M[k] - 1) : int'(mq[k] == 0);
         check($sformatf("%s_q%0d", ph, k),    get_q(k),  mq[k]);
         check($sformatf("%s_nq%0d", ph, k),   get_nq(k), (~mq[k]) & MSK[k]);
         check($sformatf("%s_wrap%0d", ph, k), get_w(k),  mw[k]);
         check($sformatf("%s_tc%0d", ph, k),   get_tc(k), exp_tc);
      end
   endtask

   // One cycle: apply inputs mid-cycle, check, then take the edge and check.
   task automatic drive(input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] dv);
      @(negedge clk);
      rst = r; en = e; up = u; load = l; d = dv;
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            mq[k] = RV[k];
            mw[k] = 0;
         end
      end
      #1;
      check_all("mid");
      @(posedge clk);
      model_edge();
      #1;
      check_all("edge");
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
      for (int k = 0; k < 4; k++) begin
         mq[k] = RV[k];
         mw[k] = 0;
      end
      #1;
      check("reset_q0", int'(q0), 3);
      check("reset_nq0", int'(nq0), 12);
      check("reset_wrap0", int'(w0), 0);
      check_all("reset");

      // Release, then load 0 and count up across the M10 wrap.
      drive(0, 0, 1, 0, 4'd0);
      drive(0, 0, 1, 1, 4'd0);
      for (int i = 0; i < 12; i++) drive(0, 1, 1, 0, 4'd0);

      // Count down from 1: wrap versus saturate.
      drive(0, 0, 0, 1, 4'd1);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 4'd0);

      // Load beats a terminal-count wrap; out-of-range load clamps.
      drive(0, 0, 1, 1, 4'd9);
      drive(0, 1, 1, 1, 4'd7);
      check("load_pri_q0", int'(q0), 7);
      check("load_pri_wrap0", int'(w0), 0);
      drive(0, 0, 1, 1, 4'd14);
      check("clamp_q0", int'(q0), 9);
      check("clamp_tc0", int'(tc0), 1);

      // Hold with en=0, then tc follows up without a clock.
      drive(0, 0, 1, 1, 4'd5);
      for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 4'd0);
      check("hold_q0", int'(q0), 5);
      drive(0, 0, 1, 1, 4'd0);
      drive(0, 0, 0, 0, 4'd0);
      check("tc_down_at0", int'(tc1), 1);
      drive(0, 0, 1, 0, 4'd0);

      // Full-range binary wrap.
      drive(0, 0, 1, 1, 4'd15);
      drive(0, 1, 1, 0, 4'd0);
      check("full_q2", int'(q2), 0);
      check("full_wrap2", int'(w2), 1);
      check("full_nq2", int'(nq2), 15);

      // Direction flips: back-to-back wraps on the M2 counter.
      for (int i = 0; i < 4; i++) drive(0, 1, (i % 2) == 1, 0, 4'd0);

      // Reset mid-count with unknown en/up, then resume from RESET_VAL.
      drive(0, 1, 1, 0, 4'd0);
      drive(1, 1'bx, 1'bx, 0, 4'd0);
      check("midrst_q0", int'(q0), 3);
      check("midrst_wrap0", int'(w0), 0);
      drive(0, 1, 1, 0, 4'd0);
      check("resume_q0", int'(q0), 4);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0),
               4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised synchronous up/down counter built from a bank of WIDTH T flip-flop stages, each bit updated as q[i] <= q[i] ^ t[i].
- It is the multi-bit successor to the single-bit toggle flip-flop.
- It adds a programmable modulus, direction control, parallel load, wrap/saturate mode, and terminal-count/wrap flags.
- It is used as the general counter primitive in later lab designs (dividers, sequencers).

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 16, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2^WIDTH.
- SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the end value.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, count enable.
- up, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous parallel load.
- d, input, WIDTH, load value.
- q, output, WIDTH, current count (register).
- nq, output, WIDTH, bitwise complement of q (always ~q, including during reset).
- tc, output, 1, terminal count (combinational).
- wrap, output, 1, registered one-cycle pulse.

Behaviour:
- Reset (async, active-high):
  - While rst = 1: q = RESET_VAL, nq = ~RESET_VAL, wrap = 0, immediately and independent of clk.
  - Deassertion takes effect at the next rising edge; the first count can happen on the first edge with rst = 0.
- Priority at each rising edge: rst > load > en > hold.
- load = 1:
  - q <= d if d < MODULUS, otherwise q <= MODULUS-1 (clamp).
  - en and up are ignored; wrap <= 0.
- en = 1, load = 0, up = 1:
  - If q < MODULUS-1: q <= q+1.
  - If q == MODULUS-1: SATURATE=0 gives q <= 0 and wrap <= 1; SATURATE=1 holds q and wrap <= 0.
- en = 1, load = 0, up = 0:
  - If q > 0: q <= q-1.
  - If q == 0: SATURATE=0 gives q <= MODULUS-1 and wrap <= 1; SATURATE=1 holds q and wrap <= 0.
- en = 0, load = 0: q holds; wrap <= 0.
- wrap is high for exactly the one cycle following the edge that wrapped. Back-to-back wraps (e.g. MODULUS = 2, repeated direction flips) give wrap high on consecutive cycles.
- tc:
  - Combinational: tc = (up && q == MODULUS-1) || (!up && q == 0).
  - Does not depend on en; follows up immediately when direction changes.
- Internal structure:
  - Per-bit toggle vector t, computed from q, up, en, load, d and the terminal state.
  - The next state is exactly as specified above.
  - When MODULUS = 2^WIDTH, natural binary carry/borrow gives the wrap.
  - When MODULUS < 2^WIDTH, the terminal-state toggle vector forces the jump to 0 or MODULUS-1. q must never hold a value >= MODULUS.
- Arithmetic: unsigned, WIDTH bits, no intermediate overflow outside the range.
- Reset mid-count: q goes to RESET_VAL at once and the wrap pulse is cancelled. Counting resumes from RESET_VAL on the first edge after release.
- Simultaneous load and terminal count: load wins, no wrap pulse.
- X on T-like inputs (en, up) while rst = 1 must not disturb q.

Test Plan:
- Reset: WIDTH=4, MODULUS=10, RESET_VAL=3. Assert rst mid-cycle with clk idle -> q=3, nq=4'b1100, wrap=0 before the next clk edge.
- Up wrap: MODULUS=10, SATURATE=0, en=1, up=1 from q=0 for 12 edges -> q runs 1..9,0,1,2. tc=1 while q=9. wrap=1 only in the cycle q=0 after 9.
- Down wrap / saturate: up=0 from q=1. With SATURATE=0 -> q=0 then 9, wrap pulses. With SATURATE=1 -> q=0, 0, 0 and wrap stays 0.
- Load priority and clamp: load=1, en=1, d=7 at q=9 -> q=7, no wrap. Then load d=14 -> q=9 (clamped), tc=1 with up=1.
- Enable / hold: en=0 for 5 edges at q=5 -> q=5 throughout. Toggle up with en=0 -> tc follows (q=0 with up=0 gives tc=1) and q stays unchanged.
- Full-range binary: WIDTH=4, MODULUS=16, up=1 from q=15 -> q=0, wrap=1, nq=4'b1111.
